memory_map_ctrl: RTL and testbench
==================================

// Module: memory_map_ctrl
// PURPOSE
//  Parametrised Hack data-memory map: RAM, screen buffer and buffered keyboard behind one CPU port.
//  Adds registered reads, a second screen read port for the display, a keyboard queue with ack
//  handshake, and invalid-address error reporting. Sits between CPU data port and display/kbd I/O.
// PARAMETERS
//  DATA_W    16  word width
//  ADDR_W    15  CPU address width
//  RAM_AW    14  RAM address bits; RAM_SIZE = 2**RAM_AW words
//  SCR_AW    13  screen address bits; SCR_SIZE = 2**SCR_AW words
//  KBD_DEPTH 4   keyboard queue depth (>=2, power of 2; used only with KBD_FIFO_EN)
//  Constraint: RAM_SIZE + SCR_SIZE + 1 <= 2**ADDR_W
// PORTS
//  clk          in  1       single clock, all state on rising edge
//  reset        in  1       asynchronous, active-high
//  in           in  DATA_W  CPU write data
//  address      in  ADDR_W  CPU address
//  load         in  1       CPU write enable
//  out          out DATA_W  CPU read data (registered)
//  kbd_code     in  DATA_W  key code from keyboard interface
//  kbd_strobe   in  1       1-cycle pulse: kbd_code valid
//  kbd_pending  out 1       queue non-empty
//  kbd_overflow out 1       sticky: key code lost
//  scr_addr     in  SCR_AW  display read address
//  scr_data     out DATA_W  display read data (registered)
//  err          out 1       1-cycle pulse: write to invalid address
// BEHAVIOUR
//  - Decode: RAM [0,RAM_SIZE); SCREEN [RAM_SIZE,RAM_SIZE+SCR_SIZE); KBD = RAM_SIZE+SCR_SIZE;
//    all higher addresses INVALID. Defaults: 0-16383, 16384-24575, 24576, 24577-32767.
//  - Read latency 1: out at edge N+1 = word at address sampled at edge N. Read-before-write:
//    load to the read address returns the OLD word; new value visible next cycle.
//  - KBD read returns queue head, 0 if empty. INVALID read returns 0.
//  - load=1: RAM/SCREEN write word at offset (address - region base).
//    KBD: write is the ack; pops head if non-empty, no-op if empty; data ignored.
//    INVALID: no write; err=1 for exactly the following cycle.
//  - Display port: scr_data at edge N+1 = screen[scr_addr sampled at edge N]; independent of
//    CPU port. Same-edge CPU write to that word: scr_data returns OLD word.
//  - kbd_strobe: push kbd_code. Same edge as ack: pop then push, never overflow, even when full.
//    Ack while empty + strobe: push only. KBD read on ack edge returns pre-pop head.
//  - kbd_pending = queue count != 0 (registered state, no combinational path from inputs).
//  - kbd_overflow sets when a strobe is lost, holds until reset.
//  - Reset: out=0, scr_data=0, err=0, kbd_pending=0, kbd_overflow=0, queue pointers/count
//    cleared. RAM and screen arrays are NOT cleared. Reset mid-access aborts that write.
// CONFIGURATION
//  KBD_FIFO_EN defined: keyboard queue is a KBD_DEPTH-entry FIFO; strobe with count=KBD_DEPTH
//   and no same-edge ack is dropped, queue unchanged, kbd_overflow set.
//  KBD_FIFO_EN undefined: single holding register (KBD_DEPTH ignored); strobe while full
//   overwrites the held code and sets kbd_overflow; strobe + ack same edge holds new code.
// TESTING
//  1 RAM: load=1 addr=5 in=16'h1234, then addr=5 load=0 -> out=16'h1234 one cycle after read edge;
//    same-edge read/write addr=5 in=16'hBEEF -> out=16'h1234, next cycle 16'hBEEF.
//  2 Screen dual port: CPU write addr=16384 in=16'hFFFF; scr_addr=0 next cycle ->
//    scr_data=16'hFFFF; RAM addr 0 unchanged.
//  3 Keyboard: strobe codes 65,66; read addr=24576 -> out=65, kbd_pending=1; ack write ->
//    out=66; ack -> out=0, kbd_pending=0.
//  4 Overflow (KBD_FIFO_EN, depth 4): 5 strobes -> kbd_overflow=1, reads give codes 1-4;
//    without macro: strobes 1,2 -> out=2, kbd_overflow=1.
//  5 Invalid: load=1 addr=24577 -> err=1 for one cycle, out=0 on read, no RAM/screen word changed.
//  6 Reset: assert reset between clock edges with queue holding 3 codes -> out, kbd_pending,
//    kbd_overflow, err=0 immediately; prior RAM contents still readable after release.

Source files
------------

// File: rtl/memory_map_ctrl.sv
// rtl/memory_map_ctrl.sv - Hack data-memory map: RAM, dual-port screen buffer, keyboard queue.
// Define KBD_FIFO_EN for a KBD_DEPTH-entry keyboard FIFO; otherwise a single holding register.
module memory_map_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int RAM_AW    = 14,
  parameter int SCR_AW    = 13,
  parameter int KBD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  output logic [DATA_W-1:0] out,
  input  logic [DATA_W-1:0] kbd_code,
  input  logic              kbd_strobe,
  output logic              kbd_pending,
  output logic              kbd_overflow,
  input  logic [SCR_AW-1:0] scr_addr,
  output logic [DATA_W-1:0] scr_data,
  output logic              err
);

  localparam int RAM_SIZE = 1 << RAM_AW;
  localparam int SCR_SIZE = 1 << SCR_AW;
  localparam int KBD_ADDR = RAM_SIZE + SCR_SIZE;
  localparam logic [ADDR_W:0] RAM_END = (ADDR_W + 1)'(RAM_SIZE);
  localparam logic [ADDR_W:0] KBD_AX  = (ADDR_W + 1)'(KBD_ADDR);

  if (KBD_DEPTH < 2 || (KBD_DEPTH & (KBD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("KBD_DEPTH must be a power of 2 and at least 2");
  end
  if (KBD_ADDR + 1 > (1 << ADDR_W)) begin : g_bad_map
    $error("RAM and screen do not fit in the CPU address space");
  end

  logic [ADDR_W:0]   addr_x;
  logic              sel_ram, sel_scr, sel_kbd, sel_inv;
  logic [RAM_AW-1:0] ram_off;
  logic [SCR_AW-1:0] scr_off;
  logic              kbd_ack;
  logic [DATA_W-1:0] kbd_head;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] ram [RAM_SIZE];
  logic [DATA_W-1:0] scr [SCR_SIZE];

  assign addr_x  = {1'b0, address};
  assign sel_ram = addr_x < RAM_END;
  assign sel_kbd = addr_x == KBD_AX;
  assign sel_scr = !sel_ram && (addr_x < KBD_AX);
  assign sel_inv = addr_x > KBD_AX;
  assign ram_off = RAM_AW'(address);
  assign scr_off = SCR_AW'(address - ADDR_W'(RAM_SIZE));
  assign kbd_ack = load && sel_kbd;

  // Arrays are never cleared; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && load) begin
      if (sel_ram) ram[ram_off] <= in;
      if (sel_scr) scr[scr_off] <= in;
    end
  end

`ifdef KBD_FIFO_EN
  localparam int PW = $clog2(KBD_DEPTH);
  localparam int CW = $clog2(KBD_DEPTH + 1);

  logic [DATA_W-1:0] kq [KBD_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic              pop, push;

  // An ack on the same edge frees a slot, so a strobe into a full queue still lands.
  assign pop  = kbd_ack && (count != '0);
  assign push = kbd_strobe && ((count != CW'(KBD_DEPTH)) || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      kbd_overflow <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (kbd_strobe && !push) kbd_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) kq[wr_ptr] <= kbd_code;
  end

  assign kbd_head    = (count != '0) ? kq[rd_ptr] : '0;
  assign kbd_pending = count != '0;
`else
  logic [DATA_W-1:0] kbd_hold;
  logic              kbd_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_hold     <= '0;
      kbd_full     <= 1'b0;
      kbd_overflow <= 1'b0;
    end else if (kbd_strobe) begin
      kbd_hold <= kbd_code;
      kbd_full <= 1'b1;
      if (kbd_full && !kbd_ack) kbd_overflow <= 1'b1;
    end else if (kbd_ack) begin
      kbd_full <= 1'b0;
    end
  end

  assign kbd_head    = kbd_full ? kbd_hold : '0;
  assign kbd_pending = kbd_full;
`endif

  always_comb begin
    rd_word = '0;
    if (sel_ram)      rd_word = ram[ram_off];
    else if (sel_scr) rd_word = scr[scr_off];
    else if (sel_kbd) rd_word = kbd_head;
  end

  // Reads sample the arrays before this edge's write, giving read-before-write on both ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out      <= '0;
      scr_data <= '0;
      err      <= 1'b0;
    end else begin
      out      <= rd_word;
      scr_data <= scr[scr_addr];
      err      <= load && sel_inv;
    end
  end

endmodule

// File: tb/tb_memory_map_ctrl.sv
// tb/tb_memory_map_ctrl.sv - directed self-checking bench for memory_map_ctrl.
module tb_memory_map_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_in;
  logic [14:0] address;
  logic        load;
  logic [15:0] cpu_out;
  logic [15:0] kbd_code;
  logic        kbd_strobe;
  logic        kbd_pending;
  logic        kbd_overflow;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  memory_map_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .in           (cpu_in),
    .address      (address),
    .load         (load),
    .out          (cpu_out),
    .kbd_code     (kbd_code),
    .kbd_strobe   (kbd_strobe),
    .kbd_pending  (kbd_pending),
    .kbd_overflow (kbd_overflow),
    .scr_addr     (scr_addr),
    .scr_data     (scr_data),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; address = '0; cpu_in = '0;
    kbd_code = '0; kbd_strobe = 1'b0; scr_addr = '0;
    tick; tick;
    check("rst_out", cpu_out, 16'h0);
    check("rst_scr", scr_data, 16'h0);
    check("rst_err", 16'(err), 16'h0);
    check("rst_pending", 16'(kbd_pending), 16'h0);
    check("rst_overflow", 16'(kbd_overflow), 16'h0);
    reset = 1'b0;

    // RAM write, read, read-before-write
    address = 15'd5; cpu_in = 16'h1234; load = 1'b1; tick;
    load = 1'b0; tick;
    check("ram_read", cpu_out, 16'h1234);
    load = 1'b1; cpu_in = 16'hBEEF; tick;
    check("ram_rbw_old", cpu_out, 16'h1234);
    load = 1'b0; tick;
    check("ram_rbw_new", cpu_out, 16'hBEEF);
    address = 15'd0; cpu_in = 16'h0A0A; load = 1'b1; tick;
    address = 15'd16383; cpu_in = 16'h7777; tick;
    load = 1'b0; tick;
    check("ram_last", cpu_out, 16'h7777);

    // Screen via CPU and display port
    address = 15'd16384; cpu_in = 16'hFFFF; load = 1'b1; tick;
    load = 1'b0; scr_addr = 13'd0; address = 15'd0; tick;
    check("scr_port", scr_data, 16'hFFFF);
    check("ram0_intact", cpu_out, 16'h0A0A);
    address = 15'd16384; cpu_in = 16'h1111; load = 1'b1; tick;
    check("scr_port_old", scr_data, 16'hFFFF);
    check("scr_cpu_old", cpu_out, 16'hFFFF);
    load = 1'b0; tick;
    check("scr_port_new", scr_data, 16'h1111);
    check("scr_cpu_new", cpu_out, 16'h1111);
    address = 15'd24575; cpu_in = 16'h5A5A; load = 1'b1; tick;
    load = 1'b0; scr_addr = 13'h1FFF; tick;
    check("scr_last_port", scr_data, 16'h5A5A);
    check("scr_last_cpu", cpu_out, 16'h5A5A);
    scr_addr = 13'd0;

    // Keyboard basic push/read/ack
    address = 15'd24576; kbd_code = 16'd65; kbd_strobe = 1'b1; tick;
    kbd_strobe = 1'b0;
    check("kbd_empty_read", cpu_out, 16'h0);
    check("kbd_pending1", 16'(kbd_pending), 16'h1);
    tick;
    check("kbd_head", cpu_out, 16'd65);
    load = 1'b1; tick;
    check("kbd_ack_prepop", cpu_out, 16'd65);
    check("kbd_pending0", 16'(kbd_pending), 16'h0);
    load = 1'b0; tick;
    check("kbd_after_ack", cpu_out, 16'h0);

    // Strobe and ack on the same edge while holding one code
    kbd_code = 16'd7; kbd_strobe = 1'b1; tick;
    kbd_code = 16'd8; load = 1'b1; tick;
    check("kbd_swap_prepop", cpu_out, 16'd7);
    kbd_strobe = 1'b0; load = 1'b0; tick;
    check("kbd_swap_new", cpu_out, 16'd8);
    check("kbd_swap_no_ovf", 16'(kbd_overflow), 16'h0);
    check("kbd_swap_pending", 16'(kbd_pending), 16'h1);
    load = 1'b1; tick;
    load = 1'b0;

    // Ack while empty plus strobe: push only
    kbd_code = 16'd9; kbd_strobe = 1'b1; load = 1'b1; tick;
    check("kbd_ack_empty", cpu_out, 16'h0);
    kbd_strobe = 1'b0; load = 1'b0; tick;
    check("kbd_push_only", cpu_out, 16'd9);
    load = 1'b1; tick;
    load = 1'b0; tick;
    check("kbd_drained", 16'(kbd_pending), 16'h0);

    // Overflow
`ifdef KBD_FIFO_EN
    for (int i = 1; i <= 5; i++) begin
      kbd_code = 16'(i); kbd_strobe = 1'b1; tick;
    end
    kbd_strobe = 1'b0;
    check("ovf_set", 16'(kbd_overflow), 16'h1);
    for (int i = 1; i <= 4; i++) begin
      load = 1'b1; tick;
      check("ovf_fifo_code", cpu_out, 16'(i));
    end
    load = 1'b0; tick;
    check("ovf_fifo_empty", cpu_out, 16'h0);
`else
    kbd_code = 16'd1; kbd_strobe = 1'b1; tick;
    kbd_code = 16'd2; tick;
    kbd_strobe = 1'b0;
    check("ovf_set", 16'(kbd_overflow), 16'h1);
    tick;
    check("ovf_hold_code", cpu_out, 16'd2);
    load = 1'b1; tick;
    load = 1'b0; tick;
    check("ovf_hold_empty", cpu_out, 16'h0);
`endif
    check("ovf_pending0", 16'(kbd_pending), 16'h0);

    // Invalid addresses
    address = 15'd24577; cpu_in = 16'hDEAD; load = 1'b1; tick;
    check("inv_err", 16'(err), 16'h1);
    check("inv_read", cpu_out, 16'h0);
    load = 1'b0; tick;
    check("inv_err_clear", 16'(err), 16'h0);
    address = 15'd32767; load = 1'b1; tick;
    check("inv_top_err", 16'(err), 16'h1);
    load = 1'b0; tick;
    check("inv_top_clear", 16'(err), 16'h0);
    address = 15'd5; tick;
    check("inv_ram5", cpu_out, 16'hBEEF);
    check("inv_scr0", scr_data, 16'h1111);
    address = 15'd16383; tick;
    check("inv_ram_last", cpu_out, 16'h7777);
    address = 15'd24575; tick;
    check("inv_scr_last", cpu_out, 16'h5A5A);

    // Asynchronous reset with three queued codes
    address = 15'd24576;
    for (int i = 0; i < 3; i++) begin
      kbd_code = 16'(16'h21 + i); kbd_strobe = 1'b1; tick;
    end
    kbd_strobe = 1'b0;
    address = 15'd5; tick;
    check("pre_rst_out", cpu_out, 16'hBEEF);
    check("pre_rst_pending", 16'(kbd_pending), 16'h1);
    check("pre_rst_ovf", 16'(kbd_overflow), 16'h1);
    load = 1'b1; cpu_in = 16'hAAAA;
    reset = 1'b1; #1;
    check("arst_out", cpu_out, 16'h0);
    check("arst_scr", scr_data, 16'h0);
    check("arst_err", 16'(err), 16'h0);
    check("arst_pending", 16'(kbd_pending), 16'h0);
    check("arst_ovf", 16'(kbd_overflow), 16'h0);
    tick; tick;
    load = 1'b0; reset = 1'b0; tick;
    check("post_rst_ram5", cpu_out, 16'hBEEF);
    address = 15'd0; tick;
    check("post_rst_ram0", cpu_out, 16'h0A0A);
    address = 15'd24576; tick;
    check("post_rst_kbd", cpu_out, 16'h0);
    check("post_rst_pending", 16'(kbd_pending), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
